// File: rtl/timer_pkg.sv
// Shared definitions for the rAVR timer clocking path: prescaler width and the
// CSn[2:0] clock-select codes also decoded by the timer core registers.
package timer_pkg;

  localparam int PSC_WIDTH = 10;

  typedef enum logic [2:0] {
    CS_STOP     = 3'd0,
    CS_DIV1     = 3'd1,
    CS_DIV8     = 3'd2,
    CS_DIV64    = 3'd3,
    CS_DIV256   = 3'd4,
    CS_DIV1024  = 3'd5,
    CS_EXT_FALL = 3'd6,
    CS_EXT_RISE = 3'd7
  } cs_e;

  // True on the last count of a 2^bits divide window, i.e. the low bits all ones.
  function automatic logic div_hit(input logic [PSC_WIDTH-1:0] cnt, input int bits);
    logic hit;
    hit = 1'b1;
    for (int i = 0; i < PSC_WIDTH; i++) begin
      if (i < bits && !cnt[i]) hit = 1'b0;
    end
    return hit;
  endfunction

endpackage

// File: rtl/timer_clk_sel.sv
// One timer clock-select channel: picks a count-enable source from the shared
// prescaler or an external edge pulse and registers it as a one-cycle tick.
module timer_clk_sel
  import timer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PSC_WIDTH-1:0] cnt_i,
  input  logic [2:0]           cs_i,
  input  logic                 rise_i,
  input  logic                 fall_i,
  output logic                 tick_o
);

  logic cond_d;
  logic tick_q;

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves cond_d unassigned (no latch).
    cond_d = 1'b0;
    case (cs_i)
      CS_STOP:     cond_d = 1'b0;
      CS_DIV1:     cond_d = 1'b1;
      CS_DIV8:     cond_d = div_hit(cnt_i, 3);
      CS_DIV64:    cond_d = div_hit(cnt_i, 6);
      CS_DIV256:   cond_d = div_hit(cnt_i, 8);
      CS_DIV1024:  cond_d = div_hit(cnt_i, 10);
      CS_EXT_FALL: cond_d = fall_i;
      CS_EXT_RISE: cond_d = rise_i;
      default:     cond_d = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= cond_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/timer_prescaler.sv
// Shared 10-bit system-clock prescaler feeding two independent clock-select
// channels (Timer0/Timer1); psr restarts the prescaler phase for divided modes.
module timer_prescaler
  import timer_pkg::*;
(
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       psr,
  input  logic [2:0] cs0,
  input  logic [2:0] cs1,
  input  logic       t0_rise,
  input  logic       t0_fall,
  input  logic       t1_rise,
  input  logic       t1_fall,
  output logic       tick0,
  output logic       tick1
);

  logic [PSC_WIDTH-1:0] cnt_q;
  logic [PSC_WIDTH-1:0] cnt_d;

  // Free-running with natural wrap 1023 -> 0; psr wins over increment.
  always_comb begin
    cnt_d = cnt_q + {{(PSC_WIDTH-1){1'b0}}, 1'b1};
    if (psr) cnt_d = '0;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  timer_clk_sel u_sel0 (
    .clk    (sys_clk),
    .rst_n  (sys_rst_n),
    .cnt_i  (cnt_q),
    .cs_i   (cs0),
    .rise_i (t0_rise),
    .fall_i (t0_fall),
    .tick_o (tick0)
  );

  timer_clk_sel u_sel1 (
    .clk    (sys_clk),
    .rst_n  (sys_rst_n),
    .cnt_i  (cnt_q),
    .cs_i   (cs1),
    .rise_i (t1_rise),
    .fall_i (t1_fall),
    .tick_o (tick1)
  );

endmodule

// File: tb/tb_timer_prescaler.sv
// Directed bench for timer_prescaler: an arithmetic reference model checked every
// cycle, plus literal expectations at hand-computed cycles of each scenario.
module tb_timer_prescaler;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       psr       = 1'b0;
  logic [2:0] cs0       = 3'd0;
  logic [2:0] cs1       = 3'd0;
  logic       t0_rise   = 1'b0;
  logic       t0_fall   = 1'b0;
  logic       t1_rise   = 1'b0;
  logic       t1_fall   = 1'b0;
  logic       tick0;
  logic       tick1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n0    = 0;
  int n1    = 0;

  timer_prescaler dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .psr       (psr),
    .cs0       (cs0),
    .cs1       (cs1),
    .t0_rise   (t0_rise),
    .t0_fall   (t0_fall),
    .t1_rise   (t1_rise),
    .t1_fall   (t1_fall),
    .tick0     (tick0),
    .tick1     (tick1)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // Reference model: counter as an integer modulo 1024, divided modes as "next count is a multiple of N".
  int   m_cnt = 0;
  logic e0    = 1'b0;
  logic e1    = 1'b0;

  function automatic logic model_cond(input logic [2:0] cs, input int cnt, input logic r, input logic f);
    int n;
    case (cs)
      3'd0: return 1'b0;
      3'd1: return 1'b1;
      3'd2: n = 8;
      3'd3: n = 64;
      3'd4: n = 256;
      3'd5: n = 1024;
      3'd6: return f;
      default: return r;
    endcase
    return ((cnt + 1) % n) == 0;
  endfunction

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_cnt = 0;
      e0    = 1'b0;
      e1    = 1'b0;
    end else begin
      e0    = model_cond(cs0, m_cnt, t0_rise, t0_fall);
      e1    = model_cond(cs1, m_cnt, t1_rise, t1_fall);
      m_cnt = psr ? 0 : (m_cnt + 1) % 1024;
    end
  end

  always @(negedge sys_clk) begin
    check("model_tick0", tick0, e0);
    check("model_tick1", tick1, e1);
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    @(posedge sys_clk);
    #2;
    sys_rst_n = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    // Scenario 1: div8 and div1024 from reset
    cs0 = 3'd2; cs1 = 3'd5;
    do_reset();
    check("rst_tick0", tick0, 1'b0);
    check("rst_tick1", tick1, 1'b0);
    for (int k = 1; k <= 1030; k++) begin
      step();
      if (cyc == 7)    check("s1_t0_c7", tick0, 1'b0);
      if (cyc == 8)    check("s1_t0_c8", tick0, 1'b1);
      if (cyc == 9)    check("s1_t0_c9", tick0, 1'b0);
      if (cyc == 16)   check("s1_t0_c16", tick0, 1'b1);
      if (cyc == 1023) check("s1_t1_c1023", tick1, 1'b0);
      if (cyc == 1024) begin
        check("s1_t1_c1024", tick1, 1'b1);
        check("s1_t0_c1024", tick0, 1'b1);
      end
      if (cyc == 1025) check("s1_t1_c1025", tick1, 1'b0);
    end

    // Scenario 2: psr pulse restarts the div64 phase
    cs0 = 3'd3; cs1 = 3'd0;
    do_reset();
    for (int k = 1; k <= 110; k++) begin
      step();
      psr = (cyc == 40);
      if (cyc == 64)  check("s2_old_phase", tick0, 1'b0);
      if (cyc == 104) check("s2_c104", tick0, 1'b0);
      if (cyc == 105) check("s2_c105", tick0, 1'b1);
    end
    psr = 1'b0;
    // psr held: clk/1 keeps ticking, divided mode is frozen
    cs0 = 3'd2; cs1 = 3'd1; psr = 1'b1;
    for (int k = 1; k <= 20; k++) step();
    check("s2_hold_div", tick0, 1'b0);
    check("s2_hold_div1", tick1, 1'b1);
    psr = 1'b0;

    // Scenario 3: external edge selection
    cs0 = 3'd7; cs1 = 3'd6;
    do_reset();
    n0 = 0; n1 = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (tick0) n0++;
      if (tick1) n1++;
      if (cyc == 11) check("s3_t0_c11", tick0, 1'b1);
      if (cyc == 16) check("s3_t0_fall_ign", tick0, 1'b0);
      if (cyc == 21) check("s3_t1_c21", tick1, 1'b1);
      if (cyc == 26) check("s3_t1_rise_ign", tick1, 1'b0);
      if (cyc == 36) check("s3_t1_both", tick1, 1'b1);
      t0_rise = (cyc == 10) || (cyc == 30);
      t0_fall = (cyc == 15);
      t1_fall = (cyc == 20) || (cyc == 35);
      t1_rise = (cyc == 25) || (cyc == 35);
    end
    check_int("s3_t0_count", n0, 2);
    check_int("s3_t1_count", n1, 2);

    // Scenario 4: clk/1 then stop
    cs0 = 3'd1; cs1 = 3'd0;
    do_reset();
    for (int k = 1; k <= 60; k++) begin
      step();
      if (cyc == 1)  check("s4_c1", tick0, 1'b1);
      if (cyc == 50) check("s4_c50", tick0, 1'b1);
      if (cyc == 51) check("s4_c51", tick0, 1'b0);
      if (cyc == 50) cs0 = 3'd0;
    end

    // Scenario 5: div256 switched to div8 without counter restart
    cs0 = 3'd4;
    do_reset();
    for (int k = 1; k <= 270; k++) begin
      step();
      if (cyc == 250) cs0 = 3'd2;
      if (cyc == 252) check("s5_c252", tick0, 1'b0);
      if (cyc == 256) check("s5_c256", tick0, 1'b1);
      if (cyc == 257) check("s5_c257", tick0, 1'b0);
      if (cyc == 264) check("s5_c264", tick0, 1'b1);
    end

    // Scenario 6: asynchronous reset mid-cycle while ticking
    cs0 = 3'd1; cs1 = 3'd1;
    do_reset();
    for (int k = 1; k <= 20; k++) step();
    check("s6_pre", tick0, 1'b1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("s6_async_t0", tick0, 1'b0);
    check("s6_async_t1", tick1, 1'b0);
    cs0 = 3'd2; cs1 = 3'd5;
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    cyc = 0;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (cyc == 1)  check("s6_r_c1", tick0, 1'b0);
      if (cyc == 8)  check("s6_r_c8", tick0, 1'b1);
      if (cyc == 16) check("s6_r_c16", tick0, 1'b1);
    end

    @(negedge sys_clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
